// File: rtl/led_seq_pkg.sv
// Shared mode and direction encodings for the LED step sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a clk-domain level; the history register resets high
// so a level already high at reset release is not reported as an edge.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic in_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_d <= 1'b1;
        end else begin
            in_d <= in;
        end
    end

    assign rise = in & ~in_d;

endmodule

// File: rtl/led_step_sequencer.sv
// LED pattern sequencer: one hold/rotate/bounce move per rising edge of step_clk,
// with a step counter and a wrap pulse for downstream logic.
module led_step_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned           WIDTH        = 8,
    parameter logic [WIDTH-1:0]      INIT_PATTERN = 8'h01,
    parameter int unsigned           CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_clk,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pat,
    output logic [WIDTH-1:0] led,
    output logic             dir,
    output logic [CNT_W-1:0] step_cnt,
    output logic             wrap
);

    logic             step;
    logic             accept;
    mode_e            mode_sel;

    logic [WIDTH-1:0] led_q,  led_nxt;
    dir_e             dir_q,  dir_nxt;
    logic [CNT_W-1:0] cnt_q,  cnt_nxt;
    logic             wrap_q, wrap_nxt;

    rise_edge_det u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (step_clk),
        .rise  (step)
    );

    assign mode_sel = mode_e'(mode);
    assign accept   = step & en & (mode_sel != MODE_HOLD) & ~load;

    always_comb begin
        led_nxt  = led_q;
        dir_nxt  = dir_q;
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;

        if (load) begin
            led_nxt = load_pat;
            dir_nxt = DIR_LEFT;
            cnt_nxt = '0;
        end else if (accept) begin
            cnt_nxt = cnt_q + CNT_W'(1);
            case (mode_sel)
                MODE_ROTL: begin
                    led_nxt  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    dir_nxt  = DIR_LEFT;
                    wrap_nxt = led_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    led_nxt  = {led_q[0], led_q[WIDTH-1:1]};
                    dir_nxt  = DIR_RIGHT;
                    wrap_nxt = led_q[0];
                end
                MODE_BOUNCE: begin
                    // Reversal moves away from the edge on the same step; an all-zero
                    // pattern never sees an edge bit and so never reverses.
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[WIDTH-1]) begin
                            dir_nxt  = DIR_RIGHT;
                            led_nxt  = led_q >> 1;
                            wrap_nxt = 1'b1;
                        end else begin
                            led_nxt  = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_nxt  = DIR_LEFT;
                            led_nxt  = led_q << 1;
                            wrap_nxt = 1'b1;
                        end else begin
                            led_nxt  = led_q >> 1;
                        end
                    end
                end
                default: begin
                    led_nxt = led_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= INIT_PATTERN;
            dir_q  <= DIR_LEFT;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            led_q  <= led_nxt;
            dir_q  <= dir_nxt;
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign led      = led_q;
    assign dir      = dir_q;
    assign step_cnt = cnt_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed self-checking bench for led_step_sequencer (WIDTH=8, CNT_W=8).
module tb_led_step_sequencer;

    logic       clk;
    logic       rst_n;
    logic       step_clk;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_pat;
    logic [7:0] led;
    logic       dir;
    logic [7:0] step_cnt;
    logic       wrap;

    int unsigned tests_run;
    int unsigned tests_failed;

    logic [17:0] got;
    logic [17:0] exp;

    led_step_sequencer #(
        .WIDTH        (8),
        .INIT_PATTERN (8'h01),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_clk (step_clk),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_pat (load_pat),
        .led      (led),
        .dir      (dir),
        .step_cnt (step_cnt),
        .wrap     (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not reach summary (got timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

    // One step_clk high cycle; returns at the negedge where the result is visible.
    task automatic pulse();
        @(negedge clk) step_clk = 1'b1;
        @(negedge clk) step_clk = 1'b0;
    endtask

    task automatic load_pattern(input logic [7:0] p);
        @(negedge clk);
        load     = 1'b1;
        load_pat = p;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step_clk = 1'b1; en = 1'b1; mode = 2'b01;
        load = 1'b0; load_pat = 8'h00;
        repeat (3) @(negedge clk);
        got = {led, dir, step_cnt, wrap};
        exp = {8'h01, 1'b0, 8'd0, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %h required %h", got, exp);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        got = {led, dir, step_cnt, wrap};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_high_step_clk_no_step: got %h required %h", got, exp);
        end
        @(negedge clk) step_clk = 1'b0;
        pulse();
        got = {led, dir, step_cnt, wrap};
        exp = {8'h02, 1'b0, 8'd1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_first_edge: got %h required %h", got, exp);
        end
    endtask

    task automatic test_rotl();
        load_pattern(8'h01);
        mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            pulse();
            got = {led, dir, step_cnt, wrap};
            exp = {8'(8'h01 << ((i + 1) % 8)), 1'b0, 8'(i + 1), (i == 7)};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL rotl_step%0d: got %h required %h", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_led [15];
        exp_led = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        load_pattern(8'h01);
        mode = 2'b11;
        for (int i = 0; i < 15; i++) begin
            pulse();
            got = {led, dir, step_cnt, wrap};
            exp = {exp_led[i], (i >= 7 && i <= 13), 8'(i + 1), (i == 7 || i == 14)};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL bounce_step%0d: got %h required %h", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_load_priority();
        mode = 2'b10;
        @(negedge clk);
        step_clk = 1'b1;
        load     = 1'b1;
        load_pat = 8'hA5;
        @(negedge clk);
        step_clk = 1'b0;
        load     = 1'b0;
        got = {led, dir, step_cnt, wrap};
        exp = {8'hA5, 1'b0, 8'd0, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL load_over_step: got %h required %h", got, exp);
        end
        pulse();
        got = {led, dir, step_cnt, wrap};
        exp = {8'hD2, 1'b1, 8'd1, 1'b1};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL rotr_after_load: got %h required %h", got, exp);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        repeat (3) pulse();
        got = {led, dir, step_cnt, wrap};
        exp = {8'hD2, 1'b1, 8'd1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL en_low_hold: got %h required %h", got, exp);
        end
        @(negedge clk) step_clk = 1'b1;
        @(negedge clk) en = 1'b1;
        repeat (3) @(negedge clk);
        got = {led, dir, step_cnt, wrap};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL en_raised_while_high: got %h required %h", got, exp);
        end
        @(negedge clk) step_clk = 1'b0;
        pulse();
        got = {led, dir, step_cnt, wrap};
        exp = {8'h69, 1'b1, 8'd2, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL en_next_edge: got %h required %h", got, exp);
        end
    endtask

    task automatic test_cnt_wrap_and_async_reset();
        load_pattern(8'h01);
        mode = 2'b01;
        repeat (256) pulse();
        got = {led, dir, step_cnt, wrap};
        exp = {8'h01, 1'b0, 8'd0, 1'b1};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL cnt_wrap_256: got %h required %h", got, exp);
        end
        repeat (3) pulse();
        mode = 2'b10;
        pulse();
        got = {led, dir, step_cnt, wrap};
        exp = {8'h04, 1'b1, 8'd4, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got %h required %h", got, exp);
        end
        @(negedge clk) step_clk = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        got = {led, dir, step_cnt, wrap};
        exp = {8'h01, 1'b0, 8'd0, 1'b0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL async_reset_no_edge: got %h required %h", got, exp);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        step_clk = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_rotl();
        test_bounce();
        test_load_priority();
        test_enable();
        test_cnt_wrap_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
